// File: rtl/accumulator_unit.sv
// 16-bit accumulator with single-cycle add/sub/load/clear and a 16-cycle shift-add multiply.
// Sits behind the shared adder datapath and registers result plus c/z/n/v flags.
module accumulator_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_operand,
  output logic [15:0] acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAdc  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpClr  = 3'b110;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] prod_q;

  logic [15:0] b_eff;
  logic        cin;
  logic [16:0] sum;
  logic        ovf;
  logic [31:0] partial;
  logic [31:0] prod_nxt;
  logic        accept;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;

  // Shared adder: SUB adds the inverted operand with a forced carry-in.
  always_comb begin
    b_eff = cmd_operand;
    cin   = 1'b0;
    if (cmd_op == OpSub) begin
      b_eff = ~cmd_operand;
      cin   = 1'b1;
    end else if (cmd_op == OpAdc) begin
      cin = flag_c;
    end
    sum = {1'b0, acc} + {1'b0, b_eff} + {16'b0, cin};
    ovf = (acc[15] == b_eff[15]) && (sum[15] != acc[15]);
  end

  always_comb begin
    partial  = mplier_q[cnt_q[3:0]] ? ({16'b0, mcand_q} << cnt_q[3:0]) : 32'b0;
    prod_nxt = prod_q + partial;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      prod_q   <= 32'h0;
      acc      <= 16'h0000;
      flag_c   <= 1'b0;
      flag_z   <= 1'b1;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            done <= 1'b1;
            case (cmd_op)
              OpLoad: begin
                acc    <= cmd_operand;
                flag_z <= (cmd_operand == 16'h0000);
                flag_n <= cmd_operand[15];
              end
              OpAdd, OpSub, OpAdc: begin
                acc    <= sum[15:0];
                flag_c <= sum[16];
                flag_v <= ovf;
                flag_z <= (sum[15:0] == 16'h0000);
                flag_n <= sum[15];
              end
              OpClr: begin
                acc    <= 16'h0000;
                flag_c <= 1'b0;
                flag_z <= 1'b1;
                flag_n <= 1'b0;
                flag_v <= 1'b0;
              end
              OpMul: begin
                done     <= 1'b0;
                mcand_q  <= acc;
                mplier_q <= cmd_operand;
                prod_q   <= 32'h0;
                cnt_q    <= 5'd0;
                busy     <= 1'b1;
                state_q  <= StMul;
              end
              OpNop:   ;
              default: ;
            endcase
          end
        end
        StMul: begin
          prod_q <= prod_nxt;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            acc     <= prod_nxt[15:0];
            flag_c  <= |prod_nxt[31:16];
            flag_v  <= 1'b0;
            flag_z  <= (prod_nxt[15:0] == 16'h0000);
            flag_n  <= prod_nxt[15];
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_q   <= 5'd0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_unit.sv
// Randomized bench for accumulator_unit against an arithmetic reference model,
// plus directed sequences with literal expectations.
module tb_accumulator_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_operand = 16'h0;
  logic [15:0] acc;
  logic        flag_c, flag_z, flag_n, flag_v, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [15:0] m_acc;
  bit          m_c, m_z, m_n, m_v, m_done;
  int          m_left;
  logic [31:0] m_prod;

  accumulator_unit dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .acc         (acc),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_v      (flag_v),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc  = 16'h0;
    m_c    = 1'b0;
    m_z    = 1'b1;
    m_n    = 1'b0;
    m_v    = 1'b0;
    m_done = 1'b0;
    m_left = 0;
    m_prod = 32'h0;
  endtask

  // What the unit must look like after one rising edge with the given inputs.
  task automatic model_edge(input bit v, input logic [2:0] op, input logic [15:0] b);
    int t, st, cin;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_acc  = m_prod[15:0];
        m_c    = |m_prod[31:16];
        m_v    = 1'b0;
        m_z    = (m_acc == 16'h0);
        m_n    = m_acc[15];
        m_done = 1'b1;
      end
    end else if (v) begin
      m_done = 1'b1;
      case (op)
        3'd1: begin
          m_acc = b;
          m_z   = (m_acc == 16'h0);
          m_n   = m_acc[15];
        end
        3'd2, 3'd4: begin
          cin   = (op == 3'd4) ? int'(m_c) : 0;
          t     = int'(m_acc) + int'(b) + cin;
          st    = int'($signed(m_acc)) + int'($signed(b)) + cin;
          m_c   = (t > 65535);
          m_v   = (st > 32767) || (st < -32768);
          m_acc = 16'(t);
          m_z   = (m_acc == 16'h0);
          m_n   = m_acc[15];
        end
        3'd3: begin
          st    = int'($signed(m_acc)) - int'($signed(b));
          m_c   = (m_acc >= b);
          m_v   = (st > 32767) || (st < -32768);
          m_acc = m_acc - b;
          m_z   = (m_acc == 16'h0);
          m_n   = m_acc[15];
        end
        3'd5: begin
          m_prod = {16'h0, m_acc} * {16'h0, b};
          m_left = 16;
          m_done = 1'b0;
        end
        3'd6: begin
          m_acc = 16'h0;
          m_c   = 1'b0;
          m_z   = 1'b1;
          m_n   = 1'b0;
          m_v   = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("acc", {16'h0, acc}, {16'h0, m_acc});
      check("flag_c", {31'h0, flag_c}, {31'h0, m_c});
      check("flag_z", {31'h0, flag_z}, {31'h0, m_z});
      check("flag_n", {31'h0, flag_n}, {31'h0, m_n});
      check("flag_v", {31'h0, flag_v}, {31'h0, m_v});
      check("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
      check("cmd_ready", {31'h0, cmd_ready}, {31'h0, (m_left == 0)});
      check("done", {31'h0, done}, {31'h0, m_done});
    end
  end

  task automatic step(input bit v, input logic [2:0] op, input logic [15:0] b);
    cmd_valid   = v;
    cmd_op      = op;
    cmd_operand = b;
    @(posedge clk);
    model_edge(v, op, b);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, {16'h0, act}, {16'h0, exp});
  endtask

  // Asserts reset between clock edges and checks the asynchronous reset values.
  task automatic do_reset();
    #2;
    rst    = 1'b1;
    chk_en = 1'b0;
    #1;
    lit("rst_acc", acc, 16'h0000);
    lit("rst_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h0004);
    lit("rst_ctl", {13'h0, cmd_ready, busy, done}, 16'h0004);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst       = 1'b0;
    chk_en    = 1'b1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [5];
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    corners[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    model_reset();
    do_reset();

    step(1, 3'd1, 16'h000F);
    step(1, 3'd2, 16'h0F0F);
    lit("add_acc", acc, 16'h0F1E);
    lit("add_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h0000);
    lit("add_done", {15'h0, done}, 16'h0001);
    step(0, 3'd0, 16'h0);

    step(1, 3'd1, 16'h7FFF);
    step(1, 3'd2, 16'h0001);
    lit("ovf_acc", acc, 16'h8000);
    lit("ovf_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h0003);
    step(1, 3'd1, 16'hFFFF);
    step(1, 3'd2, 16'h0001);
    lit("wrap_acc", acc, 16'h0000);
    lit("wrap_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h000C);
    step(1, 3'd4, 16'h0000);
    lit("adc_acc", acc, 16'h0001);

    step(1, 3'd1, 16'h0005);
    step(1, 3'd3, 16'h0007);
    lit("sub_acc", acc, 16'hFFFE);
    lit("sub_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h0002);
    step(1, 3'd3, 16'hFFFE);
    lit("sub0_acc", acc, 16'h0000);
    lit("sub0_flags", {12'h0, flag_c, flag_z, flag_n, flag_v}, 16'h000C);

    step(1, 3'd1, 16'h0123);
    step(1, 3'd5, 16'h0010);
    lit("mul_ctl", {14'h0, cmd_ready, busy}, 16'h0001);
    for (int i = 0; i < 16; i++) step(1, 3'd6, 16'h0000);
    lit("mul_acc", acc, 16'h1230);
    lit("mul_c", {15'h0, flag_c}, 16'h0000);
    lit("mul_done_ready", {14'h0, done, cmd_ready}, 16'h0003);
    step(0, 3'd0, 16'h0);

    step(1, 3'd1, 16'h1000);
    step(1, 3'd5, 16'h0010);
    for (int i = 0; i < 16; i++) step(0, 3'd0, 16'h0000);
    lit("mul2_acc", acc, 16'h0000);
    lit("mul2_cz", {14'h0, flag_c, flag_z}, 16'h0003);

    step(1, 3'd1, 16'h00FF);
    step(1, 3'd5, 16'h0003);
    for (int i = 0; i < 8; i++) step(0, 3'd0, 16'h0000);
    do_reset();
    step(0, 3'd0, 16'h0);
    lit("abort_done", {15'h0, done}, 16'h0000);
    step(1, 3'd2, 16'h0001);
    lit("post_rst_acc", acc, 16'h0001);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand());
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
